// File: rtl/bus_ctrl.sv
// bus_ctrl: 68000 bus-cycle controller.
// Decodes the CPU cycle and enables one slave: page table, ROM or RAM.
// Merges the slave dtack/berr responses back to the CPU.
// A watchdog converts a cycle that nobody answers into a bus error.
module bus_ctrl #(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [7:0]  PGTBL_PAGE = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       as,
  input  logic [7:0] addr,
  input  logic [2:0] fc,
  input  logic       write,
  input  logic       dev_dtack,
  input  logic       dev_berr,
  output logic       pgtbl_en,
  output logic       rom_en,
  output logic       ram_en,
  output logic       cpu_dtack,
  output logic       cpu_berr,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_ERR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_d;
  logic       as_q, super_q, write_q, dtack_q, berr_q;
  logic [7:0] addr_q;
  logic [7:0] addr_l;
  logic       super_l, write_l;
  logic [7:0] count, count_d;
  logic [2:0] sel, sel_d;
  logic [2:0] dec_sel;
  logic       dec_ok;
  logic [2:0] en_d;

  // Only the supervisor bit of the function code matters to the decode.
  logic unused_fc;
  assign unused_fc = ^fc[1:0];

  // Register the CPU bus inputs and the wired-OR slave responses once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      as_q    <= 1'b1;
      addr_q  <= 8'h00;
      super_q <= 1'b0;
      write_q <= 1'b0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      as_q    <= as;
      addr_q  <= addr;
      super_q <= fc[2];
      write_q <= write;
      dtack_q <= dev_dtack;
      berr_q  <= dev_berr;
    end
  end

  // Capture the cycle attributes at the moment a new cycle starts in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_l  <= 8'h00;
      super_l <= 1'b0;
      write_l <= 1'b0;
    end else if (state == ST_IDLE && !as_q) begin
      addr_l  <= addr_q;
      super_l <= super_q;
      write_l <= write_q;
    end
  end

  // Address map: select bits are {pgtbl, rom, ram}; all zero means illegal.
  always_comb begin
    dec_sel = 3'b000;
    if (addr_l == PGTBL_PAGE) begin
      if (super_l) dec_sel = 3'b100;
    end else if (addr_l <= 8'h0F) begin
      if (!write_l) dec_sel = 3'b010;
    end else if (addr_l <= 8'h7F) begin
      dec_sel = 3'b001;
    end
  end

  assign dec_ok = |dec_sel;

  // Next-state, watchdog and slave-select logic.
  always_comb begin
    state_d = state;
    count_d = count;
    sel_d   = sel;
    case (state)
      ST_IDLE: begin
        if (!as_q) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (as_q) begin
          state_d = ST_IDLE;
        end else if (!dec_ok) begin
          state_d = ST_ERR;
        end else begin
          sel_d   = dec_sel;
          count_d = 8'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (as_q) begin
          state_d = ST_IDLE;
        end else if (!berr_q) begin
          state_d = ST_ERR;
        end else if (!dtack_q) begin
          state_d = ST_ACK;
        end else if (count >= CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          count_d = count + 8'd1;
        end
      end
      ST_ACK: begin
        if (as_q) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (as_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign en_d = (state_d == ST_WAIT || state_d == ST_ACK) ? sel_d : 3'b000;

  // State register with registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= 8'd0;
      sel       <= 3'b000;
      pgtbl_en  <= 1'b0;
      rom_en    <= 1'b0;
      ram_en    <= 1'b0;
      cpu_dtack <= 1'b1;
      cpu_berr  <= 1'b1;
      fault     <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      sel       <= sel_d;
      pgtbl_en  <= en_d[2];
      rom_en    <= en_d[1];
      ram_en    <= en_d[0];
      cpu_dtack <= (state_d != ST_ACK);
      cpu_berr  <= (state_d != ST_ERR);
      fault     <= fault | (state_d == ST_ERR);
    end
  end

  a_onehot_en : assert property (@(posedge clk) disable iff (!reset)
    $onehot0({pgtbl_en, rom_en, ram_en}));

  a_dtack_berr_excl : assert property (@(posedge clk) disable iff (!reset)
    (cpu_dtack || cpu_berr));

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: directed scenarios for the bus-cycle controller.
module tb_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       as;
  logic [7:0] addr;
  logic [2:0] fc;
  logic       write;
  logic       dev_dtack;
  logic       dev_berr;
  logic       pgtbl_en, rom_en, ram_en, cpu_dtack, cpu_berr, fault;

  int checks = 0;
  int errors = 0;

  // Observed bundle: {pgtbl_en, rom_en, ram_en, cpu_dtack, cpu_berr, fault}
  logic [5:0] obs;
  assign obs = {pgtbl_en, rom_en, ram_en, cpu_dtack, cpu_berr, fault};

  bus_ctrl #(.TIMEOUT(64), .PGTBL_PAGE(8'hF0)) dut (
    .clk       (clk),
    .reset     (reset),
    .as        (as),
    .addr      (addr),
    .fc        (fc),
    .write     (write),
    .dev_dtack (dev_dtack),
    .dev_berr  (dev_berr),
    .pgtbl_en  (pgtbl_en),
    .rom_en    (rom_en),
    .ram_en    (ram_en),
    .cpu_dtack (cpu_dtack),
    .cpu_berr  (cpu_berr),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset;
    as = 1'b1; addr = 8'h00; fc = 3'b000; write = 1'b0;
    dev_dtack = 1'b1; dev_berr = 1'b1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  // Drive as low; after three edges the enable (or berr) is visible.
  task automatic start_cycle(input logic [7:0] a, input logic [2:0] f, input logic w);
    as = 1'b0; addr = a; fc = f; write = w;
    tick(3);
  endtask

  task automatic end_cycle;
    as = 1'b1;
    tick(2);
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (obs !== 6'b000110) begin
      errors++;
      $display("[TB] FAIL reset_state got=%b exp=%b", obs, 6'b000110);
    end
  endtask

  task automatic test_ram_read;
    start_cycle(8'h20, 3'b101, 1'b0);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL ram_en_up got=%b exp=%b", obs, 6'b001110); end
    tick(2);
    dev_dtack = 1'b0;
    tick(1);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL ram_no_ack_yet got=%b exp=%b", obs, 6'b001110); end
    tick(1);
    checks++;
    if (obs !== 6'b001010) begin errors++; $display("[TB] FAIL ram_ack got=%b exp=%b", obs, 6'b001010); end
    dev_dtack = 1'b1;
    tick(3);
    checks++;
    if (obs !== 6'b001010) begin errors++; $display("[TB] FAIL ram_ack_held got=%b exp=%b", obs, 6'b001010); end
    as = 1'b1;
    tick(1);
    checks++;
    if (obs !== 6'b001010) begin errors++; $display("[TB] FAIL ram_ack_until_as got=%b exp=%b", obs, 6'b001010); end
    tick(1);
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL ram_idle got=%b exp=%b", obs, 6'b000110); end
  endtask

  task automatic test_pgtbl;
    start_cycle(8'hF0, 3'b110, 1'b0);
    checks++;
    if (obs !== 6'b100110) begin errors++; $display("[TB] FAIL pgtbl_en_up got=%b exp=%b", obs, 6'b100110); end
    dev_dtack = 1'b0;
    tick(2);
    checks++;
    if (obs !== 6'b100010) begin errors++; $display("[TB] FAIL pgtbl_ack got=%b exp=%b", obs, 6'b100010); end
    dev_dtack = 1'b1;
    end_cycle();
    start_cycle(8'hF0, 3'b010, 1'b0);
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("[TB] FAIL pgtbl_user_berr got=%b exp=%b", obs, 6'b000101); end
    end_cycle();
    checks++;
    if (obs !== 6'b000111) begin errors++; $display("[TB] FAIL pgtbl_user_idle got=%b exp=%b", obs, 6'b000111); end
  endtask

  // Fault is set on entry; an async reset mid-WAIT must clear everything.
  task automatic test_async_reset;
    start_cycle(8'hF0, 3'b110, 1'b0);
    checks++;
    if (obs !== 6'b100111) begin errors++; $display("[TB] FAIL async_pre got=%b exp=%b", obs, 6'b100111); end
    tick(1);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL async_reset got=%b exp=%b", obs, 6'b000110); end
    as = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_illegal;
    apply_reset();
    start_cycle(8'h05, 3'b101, 1'b1);
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("[TB] FAIL rom_write_berr got=%b exp=%b", obs, 6'b000101); end
    end_cycle();
    checks++;
    if (obs !== 6'b000111) begin errors++; $display("[TB] FAIL rom_write_idle got=%b exp=%b", obs, 6'b000111); end
    start_cycle(8'h90, 3'b101, 1'b0);
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("[TB] FAIL unmapped_berr got=%b exp=%b", obs, 6'b000101); end
    end_cycle();
  endtask

  task automatic test_bounds;
    apply_reset();
    start_cycle(8'h0F, 3'b001, 1'b0);
    checks++;
    if (obs !== 6'b010110) begin errors++; $display("[TB] FAIL rom_top got=%b exp=%b", obs, 6'b010110); end
    end_cycle();
    start_cycle(8'h10, 3'b001, 1'b1);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL ram_bottom got=%b exp=%b", obs, 6'b001110); end
    end_cycle();
    start_cycle(8'h80, 3'b101, 1'b0);
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("[TB] FAIL above_ram got=%b exp=%b", obs, 6'b000101); end
    end_cycle();
  endtask

  task automatic test_timeout;
    apply_reset();
    start_cycle(8'h20, 3'b101, 1'b0);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL timeout_start got=%b exp=%b", obs, 6'b001110); end
    tick(63);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL timeout_pre got=%b exp=%b", obs, 6'b001110); end
    tick(1);
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("[TB] FAIL timeout_berr got=%b exp=%b", obs, 6'b000101); end
    end_cycle();
  endtask

  task automatic test_both_low;
    apply_reset();
    start_cycle(8'h40, 3'b101, 1'b0);
    dev_dtack = 1'b0;
    dev_berr  = 1'b0;
    tick(1);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL both_low_pre got=%b exp=%b", obs, 6'b001110); end
    tick(1);
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("[TB] FAIL both_low_berr got=%b exp=%b", obs, 6'b000101); end
    dev_dtack = 1'b1;
    dev_berr  = 1'b1;
    end_cycle();
    checks++;
    if (obs !== 6'b000111) begin errors++; $display("[TB] FAIL both_low_idle got=%b exp=%b", obs, 6'b000111); end
  endtask

  task automatic test_abort;
    apply_reset();
    start_cycle(8'h7F, 3'b101, 1'b1);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL abort_start got=%b exp=%b", obs, 6'b001110); end
    tick(1);
    as = 1'b1;
    tick(1);
    checks++;
    if (obs !== 6'b001110) begin errors++; $display("[TB] FAIL abort_pre got=%b exp=%b", obs, 6'b001110); end
    tick(1);
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL abort_idle got=%b exp=%b", obs, 6'b000110); end
    tick(2);
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL abort_quiet got=%b exp=%b", obs, 6'b000110); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    start_cycle(8'h20, 3'b101, 1'b0);
    dev_dtack = 1'b0;
    tick(2);
    checks++;
    if (obs !== 6'b001010) begin errors++; $display("[TB] FAIL b2b_first_ack got=%b exp=%b", obs, 6'b001010); end
    dev_dtack = 1'b1;
    as = 1'b1;
    tick(1);
    as = 1'b0; addr = 8'h05; fc = 3'b101; write = 1'b0;
    tick(1);
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL b2b_idle got=%b exp=%b", obs, 6'b000110); end
    tick(1);
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL b2b_decode got=%b exp=%b", obs, 6'b000110); end
    tick(1);
    checks++;
    if (obs !== 6'b010110) begin errors++; $display("[TB] FAIL b2b_rom_en got=%b exp=%b", obs, 6'b010110); end
    dev_dtack = 1'b0;
    tick(2);
    checks++;
    if (obs !== 6'b010010) begin errors++; $display("[TB] FAIL b2b_rom_ack got=%b exp=%b", obs, 6'b010010); end
    dev_dtack = 1'b1;
    end_cycle();
    checks++;
    if (obs !== 6'b000110) begin errors++; $display("[TB] FAIL b2b_end got=%b exp=%b", obs, 6'b000110); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset = 1'b0;
    as = 1'b1; addr = 8'h00; fc = 3'b000; write = 1'b0;
    dev_dtack = 1'b1; dev_berr = 1'b1;
    test_reset();
    test_ram_read();
    test_pgtbl();
    test_async_reset();
    test_illegal();
    test_bounds();
    test_timeout();
    test_both_low();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
